// File: rtl/sha1_stream_core.sv
// ---------------------------------------------------------------------------
// sha1_stream_core : SHA-1 block engine, one round per clock, word-stream input
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sha1_stream_core #(
  parameter logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         iInitial,
  input  logic         iValid,
  input  logic [31:0]  iDat,
  output logic         oReady,
  output logic [159:0] oDat
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_FINAL = 2'd3
  } state_t;

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    rol = (x << n) | (x >> (32 - n));
  endfunction

  state_t             state_q, state_d;
  logic [6:0]         t_q, t_d;
  logic [31:0]        a_q, b_q, c_q, d_q, e_q;
  logic [31:0]        a_d, b_d, c_d, d_d, e_d;
  logic [159:0]       h_q, h_d;
  logic [159:0]       odat_q, odat_d;
  logic               ordy_q, ordy_d;
  // w_q[0] is W[t-16], w_q[15] is W[t-1]
  logic [15:0][31:0]  w_q, w_d;

  logic [31:0] ra, rb, rc, rd, re;
  logic [31:0] w_t, f_t, k_t, t_sum;
  logic        do_round;
  logic [159:0] h_sum;

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    e_d      = e_q;
    h_d      = h_q;
    odat_d   = odat_q;
    ordy_d   = ordy_q;
    w_d      = w_q;

    // Round 0 starts from the chaining value rather than the working registers
    if (state_q == S_IDLE) begin
      if (iInitial) {ra, rb, rc, rd, re} = IV;
      else          {ra, rb, rc, rd, re} = h_q;
    end else begin
      {ra, rb, rc, rd, re} = {a_q, b_q, c_q, d_q, e_q};
    end

    if (state_q == S_ROUND) w_t = rol(w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0], 1);
    else                    w_t = iDat;

    if (t_q < 7'd20) begin
      f_t = (rb & rc) | (~rb & rd);
      k_t = 32'h5a827999;
    end else if (t_q < 7'd40) begin
      f_t = rb ^ rc ^ rd;
      k_t = 32'h6ed9eba1;
    end else if (t_q < 7'd60) begin
      f_t = (rb & rc) | (rb & rd) | (rc & rd);
      k_t = 32'h8f1bbcdc;
    end else begin
      f_t = rb ^ rc ^ rd;
      k_t = 32'hca62c1d6;
    end

    t_sum = rol(ra, 5) + f_t + re + k_t + w_t;

    h_sum = {h_q[159:128] + a_q, h_q[127:96] + b_q, h_q[95:64] + c_q,
             h_q[63:32] + d_q, h_q[31:0] + e_q};

    do_round = ((state_q == S_IDLE || state_q == S_LOAD) && iValid) ||
               (state_q == S_ROUND);

    if (do_round) begin
      a_d = t_sum;
      b_d = ra;
      c_d = rol(rb, 30);
      d_d = rc;
      e_d = rd;
      w_d = {w_t, w_q[15:1]};
      t_d = (t_q == 7'd79) ? 7'd0 : t_q + 7'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (iValid) begin
          state_d = S_LOAD;
          ordy_d  = 1'b0;
          if (iInitial) h_d = IV;
        end
      end
      S_LOAD: begin
        if (iValid && t_q == 7'd15) state_d = S_ROUND;
      end
      S_ROUND: begin
        if (t_q == 7'd79) state_d = S_FINAL;
      end
      default: begin
        h_d     = h_sum;
        odat_d  = h_sum;
        ordy_d  = 1'b1;
        t_d     = 7'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      t_q     <= 7'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      c_q     <= 32'd0;
      d_q     <= 32'd0;
      e_q     <= 32'd0;
      h_q     <= IV;
      odat_q  <= 160'd0;
      ordy_q  <= 1'b1;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      e_q     <= e_d;
      h_q     <= h_d;
      odat_q  <= odat_d;
      ordy_q  <= ordy_d;
      w_q     <= w_d;
    end
  end

  assign oReady = ordy_q;
  assign oDat   = odat_q;

endmodule

`default_nettype wire

// File: tb/tb_sha1_stream_core.sv
// ---------------------------------------------------------------------------
// tb_sha1_stream_core : known-answer and randomized checks against a SHA-1 model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sha1_stream_core;

  localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         iInitial = 1'b0;
  logic         iValid = 1'b0;
  logic [31:0]  iDat = 32'd0;
  logic         oReady;
  logic [159:0] oDat;

  int n_cmp = 0;
  int n_bad = 0;
  logic [159:0] h_model;
  logic [159:0] prev_digest;

  sha1_stream_core #(.IV(IV)) dut (
    .clk(clk), .reset_n(reset_n), .iInitial(iInitial), .iValid(iValid),
    .iDat(iDat), .oReady(oReady), .oDat(oDat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    rol = (x << n) | (x >> (32 - n));
  endfunction

  // Straight FIPS 180 compression: full 80-word schedule, then 80 rounds
  function automatic logic [159:0] sha1_ref(input logic [159:0] hin, input logic [511:0] blk);
    logic [31:0] w[80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 80; t++) w[t] = rol(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
    {a, b, c, d, e} = hin;
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
      tmp = rol(a, 5) + f + e + k + w[t];
      e = d; d = c; c = rol(b, 30); b = a; a = tmp;
    end
    sha1_ref = {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c,
                hin[63:32] + d, hin[31:0] + e};
  endfunction

  // stall: 0 none, 1 random gaps; gap_at >= 1 forces a 3-cycle gap before that word
  task automatic load_words(input logic [511:0] blk, input bit init, input bit stall, input int gap_at);
    for (int i = 0; i < 16; i++) begin
      if (i > 0 && (i == gap_at || (stall && $urandom_range(0, 3) == 0))) begin
        iValid   = 1'b0;
        iDat     = $urandom;
        iInitial = 1'($urandom);
        repeat ((i == gap_at) ? 3 : $urandom_range(1, 3)) tick();
      end
      iValid   = 1'b1;
      iDat     = blk[511 - 32*i -: 32];
      iInitial = (i == 0) ? init : 1'($urandom);
      tick();
      if (i == 0) chk("ready_fall", {159'd0, oReady}, 160'd0);
    end
    iValid   = 1'b0;
    iInitial = 1'b0;
  endtask

  task automatic finish_block(input logic [159:0] exp, input bit pulse);
    int n = 0;
    while (!oReady && n < 200) begin
      if (pulse) begin
        iValid   = 1'($urandom);
        iDat     = $urandom;
        iInitial = 1'($urandom);
      end
      tick();
      n++;
      if (n == 30) chk("digest_hold", oDat, prev_digest);
    end
    iValid   = 1'b0;
    iInitial = 1'b0;
    chk("latency", 160'(n), 160'd65);
    chk("digest", oDat, exp);
    prev_digest = exp;
  endtask

  task automatic run_block(input logic [511:0] blk, input bit init, input bit stall,
                           input int gap_at, input bit pulse, output logic [159:0] dig);
    dig = sha1_ref(init ? IV : h_model, blk);
    h_model = dig;
    load_words(blk, init, stall, gap_at);
    finish_block(dig, pulse);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] blk_abc, blk_empty, blk_t3a, blk_t3b, blk_rnd;
    logic [159:0] dig, dig2;
    blk_abc   = {32'h61626380, 448'd0, 32'h00000018};
    blk_empty = {32'h80000000, 480'd0};
    blk_t3a   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    blk_t3b   = {480'd0, 32'h000001c0};
    h_model     = IV;
    prev_digest = 160'd0;

    repeat (3) tick();
    chk("reset_ready", {159'd0, oReady}, 160'd1);
    chk("reset_odat", oDat, 160'd0);
    reset_n = 1'b1;
    tick();

    // chaining value after reset is IV, so iInitial=0 still hashes from IV
    run_block(blk_empty, 1'b0, 1'b0, -1, 1'b0, dig);
    chk("t2_noinit_kat", dig, 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709);

    run_block(blk_abc, 1'b1, 1'b0, -1, 1'b0, dig);
    chk("t1_kat", oDat, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);

    // back-to-back: T2 word 0 on the first edge after oReady rises
    run_block(blk_empty, 1'b1, 1'b0, -1, 1'b0, dig);
    chk("t6_kat", oDat, 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709);

    run_block(blk_t3a, 1'b1, 1'b0, -1, 1'b0, dig);
    run_block(blk_t3b, 1'b0, 1'b0, -1, 1'b0, dig);
    chk("t3_kat", oDat, 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1);
    run_block(blk_t3b, 1'b1, 1'b0, -1, 1'b0, dig2);
    chk("t3_differs", {159'd0, (oDat != dig)}, 160'd1);

    // stall mid-load plus junk on the inputs during rounds
    run_block(blk_abc, 1'b1, 1'b0, 7, 1'b1, dig);
    chk("t4_kat", oDat, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);

    // asynchronous reset in the middle of the round phase
    load_words(blk_abc, 1'b1, 1'b0, -1);
    repeat (20) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("t5_ready", {159'd0, oReady}, 160'd1);
    chk("t5_odat", oDat, 160'd0);
    tick();
    #2 reset_n = 1'b1;
    tick();
    h_model     = IV;
    prev_digest = 160'd0;
    run_block(blk_abc, 1'b1, 1'b0, -1, 1'b0, dig);
    chk("t5_rerun_kat", oDat, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);

    for (int r = 0; r < 16; r++) begin
      for (int j = 0; j < 16; j++) blk_rnd[32*j +: 32] = $urandom;
      run_block(blk_rnd, (r == 0) ? 1'b1 : 1'($urandom_range(0, 3) == 0),
                1'($urandom), -1, 1'($urandom), dig);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
